param_updown_counter: RTL and testbench
=======================================

// Module: param_updown_counter
// PURPOSE
//   Parametrised up/down counter with programmable modulus, clock prescaler, parallel
//   load and one-shot mode. Drop-in counting core for the TinyTapeout wrapper top:
//   ui_in/uio_in drive controls, uo_out shows count/flags. Replaces the fixed 4-bit
//   free-running count with a configurable counter that flags terminal events.
// PARAMETERS
//   WIDTH     8   count, load value and limit width (2..16)
//   PRE_W     4   prescaler divide-field width; step every (prescale+1) enabled cycles
// PORTS
//   clk        in   1        clock
//   rst_n      in   1        reset, synchronous, active-low
//   en         in   1        count enable; prescaler and counter hold when 0
//   up_dn      in   1        1 = count up, 0 = count down
//   mode       in   2        0 FREE, 1 MODULO, 2 ONESHOT, 3 reserved (behaves as FREE)
//   limit      in   WIDTH    modulus top value (MODULO/ONESHOT); ignored in FREE
//   prescale   in   PRE_W    divide ratio minus one
//   load       in   1        synchronous parallel load strobe
//   load_val   in   WIDTH    value loaded on load
//   clr_ovf    in   1        clears sticky ovf
//   count      out  WIDTH    current count
//   tc         out  1        1-cycle terminal-count pulse
//   ovf        out  1        sticky: set on any wrap
//   done       out  1        ONESHOT finished; counter frozen
// BEHAVIOUR
//   Reset (synchronous, rst_n=0 at posedge clk): count=0, tc=0, ovf=0, done=0, prescaler=0.
//   Prescaler: pre_cnt advances on each en=1 cycle; tick when pre_cnt==prescale, then
//     pre_cnt<=0. pre_cnt>prescale (ratio lowered mid-count) -> tick and clear. prescale=0
//     -> tick every en cycle. en=0 holds pre_cnt; no tick.
//   Step on tick only; count updates on the same edge (latency 1 cycle from tick).
//   top = all-ones in FREE/reserved, limit in MODULO/ONESHOT.
//   Up:   count>=top -> terminal: FREE/MODULO wrap to 0; else count+1.
//   Down: count==0   -> terminal: FREE/MODULO wrap to top; else count-1.
//   ONESHOT: terminal value is top (up) / 0 (down). Step that reaches it sets done=1;
//     while done=1 ticks ignored, count frozen. Loading terminal value does not set done.
//   tc: registered; 1 for exactly the cycle after any edge where a wrap occurred
//     (FREE/MODULO) or done was set (ONESHOT); otherwise 0.
//   ovf: set on every wrap; clr_ovf clears; same-cycle wrap+clr_ovf -> ovf=1 (set wins).
//   load: highest priority after reset: count<=load_val, pre_cnt<=0, done<=0, tc<=0;
//     any coincident tick discarded. load_val>top allowed: next up step wraps/terminates.
//   mode/limit/up_dn changes take effect at next tick; no pipeline flush required.
//   Reset mid-count or mid-ONESHOT returns everything to reset state in one edge.
//   All arithmetic modulo 2^WIDTH; no X propagation from unused mode 3.
// STRUCTURE
//   counter_pkg: MODE_FREE/MODE_MODULO/MODE_ONESHOT localparams, mode width constant.
//   Sub-module tick_prescaler (PRE_W): en, prescale, clear(=load) -> tick.
//   Top holds count/flag registers, next-state mux and terminal detection.
// TESTING
//   FREE, WIDTH=4, prescale=0, up, en=1 from 0: 16 edges -> count 0..15,0; tc=1 cycle after
//     15->0; ovf=1 and stays until clr_ovf.
//   MODULO limit=9, prescale=2, up: count advances every 3rd cycle 0..9,0; tc once per wrap.
//   Down MODULO limit=5 from load_val=1: 1,0,5,4 with tc after 0->5; en=0 mid-run holds.
//   ONESHOT limit=3 up from 0: 0,1,2,3 then done=1, tc pulse once, further ticks ignored;
//     load 0 -> done=0, counting resumes.
//   load coincident with tick, clr_ovf coincident with wrap, rst_n=0 mid-prescale:
//     load wins, ovf stays 1, all outputs 0 next cycle.

Source files
------------

// File: rtl/param_updown_counter_pkg.sv
// Shared definitions for the parametrised up/down counter.
//   MODE_W  : width of the mode control field
//   mode_t  : counting modes; encoding 3 is reserved and counts like FREE
package param_updown_counter_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_FREE    = 2'd0,
        MODE_MODULO  = 2'd1,
        MODE_ONESHOT = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_t;

endpackage

// File: rtl/param_updown_counter_if.sv
// Control/status bundle of the up/down counter.
//   master : drives en, up_dn, mode, limit, prescale, load, load_val, clr_ovf;
//            observes count, tc, ovf, done
//   slave  : the counter core (mirror image of master)
// WIDTH and PRE_W must match the parameters of the counter it connects to.
interface param_updown_counter_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned PRE_W = 4
) ();
    import param_updown_counter_pkg::*;

    logic              en;
    logic              up_dn;
    logic [MODE_W-1:0] mode;
    logic [WIDTH-1:0]  limit;
    logic [PRE_W-1:0]  prescale;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic              clr_ovf;
    logic [WIDTH-1:0]  count;
    logic              tc;
    logic              ovf;
    logic              done;

    modport master (
        output en, up_dn, mode, limit, prescale, load, load_val, clr_ovf,
        input  count, tc, ovf, done
    );

    modport slave (
        input  en, up_dn, mode, limit, prescale, load, load_val, clr_ovf,
        output count, tc, ovf, done
    );

endinterface

// File: rtl/param_updown_counter_tick_prescaler.sv
// Clock-enable prescaler: emits one tick every (prescale+1) enabled cycles.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : advance enable; the divider holds when low
//   clear      : restart the divide period (driven by the counter's load)
//   prescale   : divide ratio minus one
//   tick       : combinational step strobe for the current cycle
module param_updown_counter_tick_prescaler #(
    parameter int unsigned PRE_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clear,
    input  logic [PRE_W-1:0] prescale,
    output logic             tick
);

    logic [PRE_W-1:0] pre_cnt;

    // ">=" rather than "==" so lowering the ratio mid-period ticks at once
    // instead of running all the way around the divider.
    assign tick = en && (pre_cnt >= prescale);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (clear) begin
            pre_cnt <= '0;
        end else if (en) begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/param_updown_counter.sv
// Up/down counter with programmable modulus, prescaler, parallel load and
// one-shot mode.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : control/status bundle (slave side), see param_updown_counter_if
//                count : current count
//                tc    : one-cycle pulse after a wrap or one-shot completion
//                ovf   : sticky wrap flag, cleared by clr_ovf (a wrap wins)
//                done  : one-shot finished; count frozen until load/reset
module param_updown_counter
    import param_updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned PRE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    param_updown_counter_if.slave bus
);

    logic             tick;
    mode_t            mode;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_nx;
    logic             done_q;
    logic             done_nx;
    logic             tc_q;
    logic             ovf_q;
    logic             wrap;

    param_updown_counter_tick_prescaler #(
        .PRE_W(PRE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (bus.en),
        .clear    (bus.load),
        .prescale (bus.prescale),
        .tick     (tick)
    );

    assign mode = mode_t'(bus.mode);

    always_comb begin
        top      = (mode == MODE_MODULO || mode == MODE_ONESHOT) ? bus.limit : '1;
        count_nx = count_q;
        done_nx  = done_q;
        wrap     = 1'b0;

        // A finished one-shot ignores ticks whatever the mode input does next.
        if (tick && !done_q) begin
            if (mode == MODE_ONESHOT) begin
                // Sitting on the terminal value (e.g. after a load) finishes
                // on the next tick without moving the count.
                if (bus.up_dn) begin
                    if (count_q >= top) begin
                        done_nx = 1'b1;
                    end else begin
                        count_nx = count_q + 1'b1;
                        done_nx  = (count_nx == top);
                    end
                end else begin
                    if (count_q == '0) begin
                        done_nx = 1'b1;
                    end else begin
                        count_nx = count_q - 1'b1;
                        done_nx  = (count_nx == '0);
                    end
                end
            end else begin
                if (bus.up_dn) begin
                    if (count_q >= top) begin
                        count_nx = '0;
                        wrap     = 1'b1;
                    end else begin
                        count_nx = count_q + 1'b1;
                    end
                end else begin
                    if (count_q == '0) begin
                        count_nx = top;
                        wrap     = 1'b1;
                    end else begin
                        count_nx = count_q - 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            done_q  <= 1'b0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (bus.load) begin
            // Load discards any coincident tick; clr_ovf still applies.
            count_q <= bus.load_val;
            done_q  <= 1'b0;
            tc_q    <= 1'b0;
            ovf_q   <= ovf_q & ~bus.clr_ovf;
        end else begin
            count_q <= count_nx;
            done_q  <= done_nx;
            tc_q    <= wrap | (done_nx & ~done_q);
            ovf_q   <= wrap | (ovf_q & ~bus.clr_ovf);
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.ovf   = ovf_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Scoreboard bench for param_updown_counter: directed scenarios followed by
// randomized control traffic, all checked against a behavioural model.
module tb_param_updown_counter;

    localparam int unsigned W = 4;
    localparam int unsigned P = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    param_updown_counter_if #(.WIDTH(W), .PRE_W(P)) bus ();

    param_updown_counter #(.WIDTH(W), .PRE_W(P)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int count;
        bit tc;
        bit ovf;
        bit done;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference state: count as a plain integer in [0, 2^W).
    int m_count = 0;
    int m_pre   = 0;
    bit m_ovf   = 0;
    bit m_done  = 0;
    bit m_tc    = 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    task automatic model_step();
        int modn;
        int top;
        int target;
        bit tick;
        bit up;
        bit terminal;
        bit wrap;
        bit oneshot;
        modn = 1 << W;
        wrap = 0;
        if (!rst_n) begin
            m_count = 0; m_pre = 0; m_ovf = 0; m_done = 0; m_tc = 0;
            return;
        end
        if (bus.load) begin
            m_count = int'(bus.load_val);
            m_pre   = 0;
            m_done  = 0;
            m_tc    = 0;
            if (bus.clr_ovf) m_ovf = 0;
            return;
        end
        tick = bus.en && (m_pre >= int'(bus.prescale));
        if (bus.en) m_pre = tick ? 0 : m_pre + 1;
        m_tc = 0;
        if (tick && !m_done) begin
            oneshot  = (bus.mode == 2'd2);
            top      = (bus.mode == 2'd1 || oneshot) ? int'(bus.limit) : modn - 1;
            up       = bus.up_dn;
            target   = up ? top : 0;
            terminal = up ? (m_count >= top) : (m_count == 0);
            if (oneshot) begin
                if (!terminal) m_count = up ? m_count + 1 : m_count - 1;
                if (terminal || m_count == target) begin
                    m_done = 1;
                    m_tc   = 1;
                end
            end else if (terminal) begin
                m_count = up ? 0 : top;
                wrap    = 1;
                m_tc    = 1;
            end else begin
                m_count = (m_count + (up ? 1 : modn - 1)) % modn;
            end
        end
        if (wrap) m_ovf = 1;
        else if (bus.clr_ovf) m_ovf = 0;
    endtask

    // One clock: model predicts at the edge, outputs settle, returns mid-low phase.
    task automatic cycle();
        @(posedge clk);
        model_step();
        sb.push_back('{m_count, m_tc, m_ovf, m_done});
        @(negedge clk);
        #2;
    endtask

    task automatic drive(input bit en, input bit up, input int mode, input int limit,
                         input int pre, input bit load, input int lval, input bit clr);
        bus.en       = en;
        bus.up_dn    = up;
        bus.mode     = 2'(mode);
        bus.limit    = W'(limit);
        bus.prescale = P'(pre);
        bus.load     = load;
        bus.load_val = W'(lval);
        bus.clr_ovf  = clr;
    endtask

    // Monitor: every post-edge sample is an output presentation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("count", int'(bus.count), e.count);
                check("tc",    int'(bus.tc),    int'(e.tc));
                check("ovf",   int'(bus.ovf),   int'(e.ovf));
                check("done",  int'(bus.done),  int'(e.done));
            end
        end
    end

    initial begin
        bit r_en;
        bit r_up;
        int r_mode;
        int r_lim;
        int r_pre;

        drive(0, 1, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        cycle();
        cycle();
        check("reset_count", int'(bus.count), 0);
        check("reset_flags", int'({bus.tc, bus.ovf, bus.done}), 0);

        // FREE, prescale 0, up from 0
        rst_n = 1'b1;
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        repeat (15) cycle();
        check("free_at_15", int'(bus.count), 15);
        check("free_no_ovf_yet", int'(bus.ovf), 0);
        cycle();
        check("free_wrap_count", int'(bus.count), 0);
        check("free_wrap_tc", int'(bus.tc), 1);
        check("free_wrap_ovf", int'(bus.ovf), 1);
        cycle();
        check("free_tc_one_cycle", int'(bus.tc), 0);
        check("free_ovf_sticky", int'(bus.ovf), 1);
        drive(1, 1, 0, 0, 0, 0, 0, 1);
        cycle();
        check("free_clr_ovf", int'(bus.ovf), 0);

        // MODULO limit 9, prescale 2, up
        drive(0, 1, 1, 9, 2, 1, 0, 0);
        cycle();
        drive(1, 1, 1, 9, 2, 0, 0, 0);
        repeat (3) cycle();
        check("mod_first_step", int'(bus.count), 1);
        repeat (27) cycle();
        check("mod_wrap_count", int'(bus.count), 0);
        check("mod_wrap_tc", int'(bus.tc), 1);
        cycle();
        check("mod_tc_cleared", int'(bus.tc), 0);

        // Down MODULO limit 5 from 1
        drive(0, 0, 1, 5, 0, 1, 1, 0);
        cycle();
        check("down_load", int'(bus.count), 1);
        drive(1, 0, 1, 5, 0, 0, 0, 0);
        cycle();
        check("down_to_0", int'(bus.count), 0);
        cycle();
        check("down_wrap_top", int'(bus.count), 5);
        check("down_wrap_tc", int'(bus.tc), 1);
        cycle();
        check("down_4", int'(bus.count), 4);
        drive(0, 0, 1, 5, 0, 0, 0, 0);
        repeat (2) cycle();
        check("down_hold", int'(bus.count), 4);

        // ONESHOT limit 3 up from 0
        drive(0, 1, 2, 3, 0, 1, 0, 1);
        cycle();
        drive(1, 1, 2, 3, 0, 0, 0, 0);
        repeat (3) cycle();
        check("os_reach", int'(bus.count), 3);
        check("os_done", int'(bus.done), 1);
        check("os_tc", int'(bus.tc), 1);
        repeat (2) cycle();
        check("os_frozen", int'(bus.count), 3);
        check("os_tc_once", int'(bus.tc), 0);
        drive(1, 1, 2, 3, 0, 1, 0, 0);
        cycle();
        check("os_reload_done", int'(bus.done), 0);
        drive(1, 1, 2, 3, 0, 0, 0, 0);
        cycle();
        check("os_resume", int'(bus.count), 1);

        // Load coincident with tick
        drive(1, 1, 0, 0, 0, 1, 7, 0);
        cycle();
        check("load_wins", int'(bus.count), 7);
        // clr_ovf coincident with wrap
        drive(0, 1, 0, 0, 0, 1, 15, 0);
        cycle();
        drive(1, 1, 0, 0, 0, 0, 0, 1);
        cycle();
        check("clr_vs_wrap_ovf", int'(bus.ovf), 1);
        check("clr_vs_wrap_count", int'(bus.count), 0);
        // Reset mid-prescale
        drive(1, 1, 0, 0, 3, 0, 0, 0);
        repeat (2) cycle();
        rst_n = 1'b0;
        cycle();
        check("midreset_count", int'(bus.count), 0);
        check("midreset_flags", int'({bus.tc, bus.ovf, bus.done}), 0);
        rst_n = 1'b1;

        // Randomized traffic
        r_en = 1; r_up = 1; r_mode = 0; r_lim = 9; r_pre = 0;
        repeat (3000) begin
            rst_n = ($urandom_range(0, 63) != 0);
            r_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0)  r_up   = ~r_up;
            if ($urandom_range(0, 31) == 0) r_mode = int'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) r_lim  = int'($urandom_range(0, (1 << W) - 1));
            if ($urandom_range(0, 15) == 0) r_pre  = int'($urandom_range(0, (1 << P) - 1));
            drive(r_en, r_up, r_mode, r_lim, r_pre,
                  $urandom_range(0, 15) == 0,
                  int'($urandom_range(0, (1 << W) - 1)),
                  $urandom_range(0, 7) == 0);
            cycle();
        end

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
